// File: rtl/note_pkg.sv
// Shared note-code definitions and sequencer state encoding for the note scroller.
package note_pkg;

  typedef logic [1:0] note_t;

  localparam note_t NOTE_NONE  = 2'd0;
  localparam note_t NOTE_RED   = 2'd1;
  localparam note_t NOTE_BLUE  = 2'd2;
  localparam note_t NOTE_GREEN = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    FETCH,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/note_decode.sv
// Combinational decode of a window of note codes into per-row R/G/B masks.
module note_decode
  import note_pkg::*;
#(
  parameter int ROWS = 10
) (
  input  note_t [ROWS-1:0] window,
  output logic  [ROWS-1:0] mask_r,
  output logic  [ROWS-1:0] mask_g,
  output logic  [ROWS-1:0] mask_b
);

  always_comb begin
    mask_r = '0;
    mask_g = '0;
    mask_b = '0;
    for (int i = 0; i < ROWS; i++) begin
      case (window[i])
        NOTE_RED:   mask_r[i] = 1'b1;
        NOTE_BLUE:  mask_b[i] = 1'b1;
        NOTE_GREEN: mask_g[i] = 1'b1;
        default:    ;
      endcase
    end
  end

endmodule

// File: rtl/note_scroller.sv
// Fetches a song's note codes from a synchronous ROM and scrolls them through
// a ROWS-deep window with sub-note pixel offsets.
//
// state | meaning
// IDLE  | waiting for start; window, index and offset hold their cleared values
// RUN   | counting pixel ticks; offset advances on each tick
// FETCH | rom_addr presents the next note index
// SHIFT | window scrolls by one row, new note (or blank) enters row 0
// DONE  | one-cycle finish pulse, then back to IDLE
module note_scroller
  import note_pkg::*;
#(
  parameter int ROWS      = 10,
  parameter int TICK_DIV  = 100000,
  parameter int SUB_STEPS = 7,
  parameter int ADDR_W    = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            song_len,
  input  logic                         pause,
  input  logic                         abort,
  output logic [ADDR_W-1:0]            rom_addr,
  input  logic [1:0]                   rom_data,
  output logic [ROWS-1:0]              note_R,
  output logic [ROWS-1:0]              note_G,
  output logic [ROWS-1:0]              note_B,
  output logic [$clog2(SUB_STEPS)-1:0] offset,
  output logic                         busy,
  output logic                         finish
);

  localparam int OFF_W = $clog2(SUB_STEPS);
  localparam int TC_W  = $clog2(TICK_DIV);
  localparam int IDX_W = ADDR_W + 1;

  state_t            state, state_next;
  note_t [ROWS-1:0]  window;
  logic [TC_W-1:0]   tick_cnt;
  logic [IDX_W-1:0]  index, index_inc, end_idx;
  logic [ADDR_W-1:0] song_len_q;
  logic              tick, wrap, aborting;
  note_t             new_note;

  always_comb begin
    state_next = state;
    tick       = !pause && (tick_cnt == TC_W'(TICK_DIV - 1));
    wrap       = tick && (offset == OFF_W'(SUB_STEPS - 1));
    aborting   = abort && (state != IDLE);
    index_inc  = index + IDX_W'(1);
    end_idx    = {1'b0, song_len_q} + IDX_W'(ROWS);
    new_note   = (index < {1'b0, song_len_q}) ? note_t'(rom_data) : NOTE_NONE;
    case (state)
      IDLE:    if (start) state_next = (song_len == '0) ? DONE : RUN;
      RUN:     if (wrap) state_next = FETCH;
      FETCH:   state_next = SHIFT;
      SHIFT:   state_next = (index_inc == end_idx) ? DONE : RUN;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (aborting) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      window     <= '0;
      tick_cnt   <= '0;
      index      <= '0;
      offset     <= '0;
      song_len_q <= '0;
      rom_addr   <= '0;
      finish     <= 1'b0;
    end else begin
      state  <= state_next;
      finish <= (state_next == DONE);
      if (state_next == FETCH) rom_addr <= index[ADDR_W-1:0];
      if (aborting) begin
        window   <= '0;
        tick_cnt <= '0;
        index    <= '0;
        offset   <= '0;
      end else if (state == IDLE) begin
        tick_cnt <= '0;
        if (start) begin
          window     <= '0;
          index      <= '0;
          offset     <= '0;
          song_len_q <= song_len;
        end
      end else begin
        // The tick counter free-runs through FETCH/SHIFT so the note period stays fixed.
        if (!pause)
          tick_cnt <= (tick_cnt == TC_W'(TICK_DIV - 1)) ? '0 : tick_cnt + TC_W'(1);
        if (state == RUN && tick)
          offset <= wrap ? '0 : offset + OFF_W'(1);
        if (state == SHIFT) begin
          window <= {window[ROWS-2:0], new_note};
          index  <= index_inc;
        end
      end
    end
  end

  assign busy = (state != IDLE);

  note_decode #(.ROWS(ROWS)) u_decode (
    .window (window),
    .mask_r (note_R),
    .mask_g (note_G),
    .mask_b (note_B)
  );

endmodule

// File: tb/tb_note_scroller.sv
// Directed bench for note_scroller; finish pulses are checked by a scoreboard monitor.
module tb_note_scroller;

  localparam int ROWS = 4, TICK_DIV = 4, SUB_STEPS = 2, ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst, start, pause, abort;
  logic [ADDR_W-1:0] song_len;
  logic [ADDR_W-1:0] rom_addr;
  logic [1:0]        rom_data = 2'd0;
  logic [ROWS-1:0]   note_R, note_G, note_B;
  logic [$clog2(SUB_STEPS)-1:0] offset;
  logic              busy, finish;

  logic [1:0] rom [16];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int c0;

  note_scroller #(
    .ROWS(ROWS), .TICK_DIV(TICK_DIV), .SUB_STEPS(SUB_STEPS), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .song_len(song_len), .pause(pause),
    .abort(abort), .rom_addr(rom_addr), .rom_data(rom_data), .note_R(note_R),
    .note_G(note_G), .note_B(note_B), .offset(offset), .busy(busy), .finish(finish)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Called at a negedge; returns with cyc equal to the first cycle after acceptance.
  task automatic launch(input int len, input bit expect_finish, input int delay, output int c);
    c = cyc + 1;
    if (expect_finish) exp_q.push_back(c + delay);
    song_len = ADDR_W'(len);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(busy), 0);
  endtask

  task automatic check_masks(input string name, input int r, input int g, input int b);
    check({name, "_R"}, int'(note_R), r);
    check({name, "_G"}, int'(note_G), g);
    check({name, "_B"}, int'(note_B), b);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 2'd3;
    rom[0] = 2'd1; rom[1] = 2'd2; rom[2] = 2'd3;
    rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; song_len = '0;

    fork
      begin : monitor
        bit prev = 1'b0;
        forever begin
          @(negedge clk);
          if (finish) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_finish: got finish=1, expected 0 (cycle %0d)", cyc);
            end else begin
              check("finish_cycle", cyc, exp_q.pop_front());
            end
            check("finish_window_empty", int'(note_R | note_G | note_B), 0);
            check("finish_single_cycle", int'(prev), 0);
          end
          prev = finish;
        end
      end
    join_none

    // Reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_masks("reset", 0, 0, 0);
    check("reset_offset", int'(offset), 0);
    check("reset_rom_addr", int'(rom_addr), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_finish", int'(finish), 0);
    repeat (5) @(negedge clk);
    check("idle_rom_addr", int'(rom_addr), 0);

    // Normal song with a start re-pulse and song_len change while busy
    launch(3, 1'b1, 58, c0);
    check("busy_after_start", int'(busy), 1);
    wait_until(c0 + 3);  check("offset_pre_tick", int'(offset), 0);
    @(negedge clk);      check("offset_post_tick", int'(offset), 1);
    wait_until(c0 + 8);  check("fetch0_rom_addr", int'(rom_addr), 0);
    check("offset_wrapped", int'(offset), 0);
    wait_until(c0 + 15);
    song_len = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("fetch1_rom_addr", int'(rom_addr), 1);
    wait_until(c0 + 25); check_masks("two_notes", 4'b0010, 4'b0000, 4'b0001);
    @(negedge clk);      check_masks("three_notes", 4'b0100, 4'b0001, 4'b0010);
    wait_idle("song1_idle");
    check("busy_drop_cycle", cyc, c0 + 59);

    // Pause for 20 cycles while offset is 1
    launch(3, 1'b1, 78, c0);
    wait_until(c0 + 4);
    pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("pause_offset_frozen", int'(offset), 1);
      @(negedge clk);
    end
    pause = 1'b0;
    wait_until(c0 + 27); check("post_pause_offset", int'(offset), 1);
    @(negedge clk);      check("post_pause_wrap", int'(offset), 0);
    wait_idle("pause_idle");

    // Abort mid-song, then replay from note 0
    launch(3, 1'b0, 0, c0);
    wait_until(c0 + 29);
    check_masks("pre_abort", 4'b0100, 4'b0001, 4'b0010);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check_masks("abort", 0, 0, 0);
    check("abort_offset", int'(offset), 0);
    repeat (70) @(negedge clk);
    check("abort_stays_idle", int'(busy), 0);
    launch(3, 1'b1, 58, c0);
    wait_until(c0 + 8);  check("replay_rom_addr", int'(rom_addr), 0);
    wait_until(c0 + 10); check_masks("replay_first", 4'b0001, 0, 0);
    wait_idle("replay_idle");

    // Empty song
    launch(0, 1'b1, 0, c0);
    check("empty_busy", int'(busy), 1);
    check_masks("empty", 0, 0, 0);
    @(negedge clk);
    check("empty_busy_drop", int'(busy), 0);

    // Reset mid-song
    repeat (3) @(negedge clk);
    launch(3, 1'b0, 0, c0);
    wait_until(c0 + 20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check_masks("midrst", 0, 0, 0);
    check("midrst_offset", int'(offset), 0);
    check("midrst_rom_addr", int'(rom_addr), 0);
    check("midrst_finish", int'(finish), 0);
    repeat (70) @(negedge clk);
    check("midrst_stays_idle", int'(busy), 0);

    check("pending_finish", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
